bullet_pool: RTL

Parametrised projectile pool that replaces the single-bullet block. It holds `NUM_BULLETS` independent projectiles, each with its own latched X, moving Y and active flag. It has edge- or hold-triggered firing with a cooldown, selectable travel direction, and a configurable step. The player cannon uses one instance (`DIR_UP=1`) and the alien fire controller uses another (`DIR_UP=0`). Colour mapper and collision logic read the flattened position buses and return a per-slot hit vector.

---
 rtl/bullet_pool.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bullet_pool.sv
// bullet_pool: NUM_BULLETS independent projectiles with edge/auto fire, cooldown,
// lowest-free-slot allocation and one IDLE/FLIGHT state machine per slot.
module bullet_slot #(
  parameter int BULLET_STEP = 4,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 479,
  parameter int DIR_UP      = 1
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       i_alloc,
  input  logic       i_hit,
  input  logic [9:0] i_spawn_x,
  input  logic [9:0] i_spawn_y,
  output logic       o_active,
  output logic [9:0] o_x,
  output logic [9:0] o_y
);
  typedef enum logic {S_IDLE = 1'b0, S_FLIGHT = 1'b1} state_t;

  localparam logic [9:0]  STEP10 = 10'(BULLET_STEP);
  localparam logic [10:0] STEP11 = 11'(BULLET_STEP);
  localparam logic [10:0] UP_LIM = 11'(Y_MIN + BULLET_STEP);
  localparam logic [10:0] DN_LIM = 11'(Y_MAX);

  state_t      r_state, w_state;
  logic [9:0]  r_x, r_y, w_x, w_y;
  logic [10:0] w_y11;
  logic        w_retire;

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
    end
  end

  // 11-bit compare so an upward shot near 0 retires instead of wrapping
  always_comb begin
    w_y11    = {1'b0, r_y};
    w_retire = (DIR_UP != 0) ? (w_y11 < UP_LIM) : ((w_y11 + STEP11) > DN_LIM);
    w_state  = r_state;
    w_x      = r_x;
    w_y      = r_y;
    case (r_state)
      S_IDLE: begin
        if (i_alloc) begin
          w_state = S_FLIGHT;
          w_x     = i_spawn_x;
          w_y     = i_spawn_y;
        end
      end
      S_FLIGHT: begin
        if (i_hit || w_retire) begin
          w_state = S_IDLE;
          w_x     = '0;
          w_y     = '0;
        end else begin
          w_y = (DIR_UP != 0) ? (r_y - STEP10) : (r_y + STEP10);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign o_active = (r_state == S_FLIGHT);
  assign o_x      = r_x;
  assign o_y      = r_y;
endmodule

module bullet_pool #(
  parameter int         NUM_BULLETS = 4,
  parameter int         BULLET_STEP = 4,
  parameter int         Y_MIN       = 0,
  parameter int         Y_MAX       = 479,
  parameter int         DIR_UP      = 1,
  parameter logic [7:0] FIRE_KEY    = 8'h2C,
  parameter int         FIRE_MODE   = 0,
  parameter int         COOLDOWN    = 8
) (
  input  logic                        frame_clk,
  input  logic                        Reset_n,
  input  logic [7:0]                  keycode,
  input  logic [9:0]                  shooter_X,
  input  logic [9:0]                  shooter_Y,
  input  logic [NUM_BULLETS-1:0]      hit,
  output logic [10*NUM_BULLETS-1:0]   bullet_X,
  output logic [10*NUM_BULLETS-1:0]   bullet_Y,
  output logic [NUM_BULLETS-1:0]      bullet_active,
  output logic                        fire_accepted,
  output logic                        fire_dropped
);
  logic [7:0]             r_key_prev;
  logic [7:0]             r_cd;
  logic                   r_acc, r_drop;
  logic                   w_req, w_fire, w_free;
  logic [NUM_BULLETS-1:0] w_alloc;

  // r_cd counts the frame of acceptance too, so a value of 1 means the
  // cooldown expires on this edge and the request may be taken.
  always_comb begin
    w_req   = (keycode == FIRE_KEY) && ((FIRE_MODE != 0) || (r_key_prev != FIRE_KEY));
    w_fire  = w_req && (r_cd <= 8'd1);
    w_alloc = '0;
    w_free  = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!bullet_active[i] && !w_free) begin
        w_alloc[i] = w_fire;
        w_free     = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      r_key_prev <= '0;
      r_cd       <= '0;
      r_acc      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_key_prev <= keycode;
      r_acc      <= w_fire && w_free;
      r_drop     <= w_fire && !w_free;
      if (w_fire && w_free)
        r_cd <= 8'(COOLDOWN);
      else if (r_cd != 8'd0)
        r_cd <= r_cd - 8'd1;
    end
  end

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
    bullet_slot #(
      .BULLET_STEP(BULLET_STEP),
      .Y_MIN      (Y_MIN),
      .Y_MAX      (Y_MAX),
      .DIR_UP     (DIR_UP)
    ) u_slot (
      .frame_clk(frame_clk),
      .Reset_n  (Reset_n),
      .i_alloc  (w_alloc[g]),
      .i_hit    (hit[g]),
      .i_spawn_x(shooter_X),
      .i_spawn_y(shooter_Y),
      .o_active (bullet_active[g]),
      .o_x      (bullet_X[10*g +: 10]),
      .o_y      (bullet_Y[10*g +: 10])
    );
  end

  assign fire_accepted = r_acc;
  assign fire_dropped  = r_drop;
endmodule
